// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-based fetch with a one-cycle memory latency.
// Optional jump predecode redirect is enabled with IFQ_JUMP_PREDECODE_EN.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  output logic [31:0]            ImemRdAddr,
  output logic                   ImemRdEn,
  input  logic [31:0]            ImemRdData,
  input  logic                   Redirect,
  input  logic [31:0]            RedirectPC,
  input  logic                   DecStall,
  output logic                   InstrValid,
  output logic [31:0]            Instruction,
  output logic [31:0]            PCPlus4,
  output logic [$clog2(DEPTH):0] QueueCount
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    RUN,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fpc_q, fpc_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic          jump;
  logic [31:0]   rsp_pc4;

  assign InstrValid  = (cnt_q != '0);
  assign Instruction = InstrValid ? instr_q[head_q] : 32'h0;
  assign PCPlus4     = InstrValid ? pc4_q[head_q] : 32'h0;
  assign QueueCount  = cnt_q;
  assign ImemRdAddr  = pc_q;
  assign ImemRdEn    = issue;

  always_comb begin
    rsp_pc4 = fpc_q + 32'd4;
    issue   = Rst && !Redirect && (state_q == RUN);
    push    = infl_q && !Redirect;
    pop     = InstrValid && !DecStall && !Redirect;
    jump    = 1'b0;
`ifdef IFQ_JUMP_PREDECODE_EN
    jump    = push && (ImemRdData[31:26] == 6'b000010);
`endif
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    infl_d  = issue;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    if (issue) begin
      pc_d  = pc_q + 32'd4;
      fpc_d = pc_q;
    end
    if (push) tail_d = tail_q + AW'(1);
    if (pop)  head_d = head_q + AW'(1);
    // jump target resolved early; the sequential fetch behind it is dropped
    if (jump) begin
      infl_d = 1'b0;
      pc_d   = {rsp_pc4[31:28], ImemRdData[25:0], 2'b00};
    end
    if (Redirect) begin
      infl_d = 1'b0;
      pc_d   = RedirectPC;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
    state_d = ((cnt_d + CW'(infl_d)) < FULL) ? RUN : HOLD;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC;
      infl_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      infl_q  <= infl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      instr_q[tail_q] <= ImemRdData;
      pc4_q[tail_q]   <= rsp_pc4;
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ImemRdAddr  output  32  instruction memory read address.
REQ-006 SHALL have port ImemRdEn  output  1  read request valid this cycle.
REQ-007 SHALL have port ImemRdData  input  32  instruction returned exactly 1 cycle after the accepted request.
REQ-008 SHALL have port Redirect  input  1  branch/jump taken from a later stage; flush and refetch.
REQ-009 SHALL have port RedirectPC  input  32  new fetch address, sampled when Redirect=1.
REQ-010 SHALL have port DecStall  input  1  decode cannot accept this cycle.
REQ-011 SHALL have port InstrValid  output  1  Instruction/PCPlus4 hold a valid head entry.
REQ-012 SHALL have port Instruction  output  32  head instruction.
REQ-013 SHALL have port PCPlus4  output  32  head instruction address + 4.
REQ-014 SHALL have port QueueCount  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL run FSM states RUN (issue allowed) and HOLD (credits exhausted); reset enters RUN.
REQ-016 SHALL issue a request (ImemRdEn=1, ImemRdAddr=fetch PC) in any cycle where QueueCount + in-flight (0 or 1) < DEPTH and Redirect=0; fetch PC then advances by 4, modulo 2^32.
REQ-017 SHALL enter HOLD when no credit remains and return to RUN in the cycle after a pop frees a credit.
REQ-018 SHALL write the returned ImemRdData with its address+4 into the tail one cycle after issue; queue never overflows.
REQ-019 SHALL pop the head when InstrValid=1 and DecStall=0; outputs show the new head next cycle.
REQ-020 SHALL support simultaneous push and pop in one cycle; QueueCount unchanged.
REQ-021 SHALL present combinationally from the head register; empty queue gives InstrValid=0, Instruction=32'h0, PCPlus4=32'h0.
REQ-022 SHALL, on Redirect=1: clear all entries, discard any in-flight response arriving next cycle, set fetch PC=RedirectPC, issue no request that cycle, and issue RedirectPC the following cycle.
REQ-023 SHALL give Redirect priority over push, pop and predecode redirect in the same cycle.
REQ-024 SHALL make first fetched instruction visible (InstrValid=1) 2 cycles after reset release or redirect.

Reset
REQ-025 SHALL, while Rst=0 at a posedge: QueueCount=0, InstrValid=0, ImemRdEn=0, ImemRdAddr=RESET_PC, in-flight flag cleared, fetch PC=RESET_PC, FSM=RUN.
REQ-026 SHALL discard any response returning in the cycle after reset deasserts if its request preceded reset.

Configuration
REQ-027 SHALL, with macro IFQ_JUMP_PREDECODE_EN defined, detect opcode 6'b000010 on ImemRdData, enqueue it normally, discard the younger in-flight request, and set fetch PC={addr+4[31:28], ImemRdData[25:0], 2'b00} (1-cycle bubble).
REQ-028 SHALL, without IFQ_JUMP_PREDECODE_EN, treat jumps as ordinary instructions; predecode logic absent.

Verification
REQ-029 SHALL test reset then DecStall=0, memory word i = i: InstrValid rises cycle 2, PCPlus4 sequence 4,8,12,... one per cycle.
REQ-030 SHALL test DecStall=1 held 10 cycles: QueueCount saturates at 4, ImemRdEn=0 in HOLD, no entry lost or duplicated on release.
REQ-031 SHALL test Redirect=1, RedirectPC=32'h100 with 3 entries queued and one in flight: next cycle QueueCount=0, InstrValid=0; first delivered PCPlus4=32'h104.
REQ-032 SHALL test Redirect and pop in same cycle with queue full: Redirect wins, no pop observed, QueueCount=0.
REQ-033 SHALL test (macro on) word at 0x8 = 32'h08000040: after it, next delivered PCPlus4=32'h104; word at 0xC never delivered.
REQ-034 SHALL test Rst=0 asserted mid-stream with 2 entries queued: next cycle all outputs at reset values; fetch restarts at RESET_PC.
